// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the 5-stage RISC-V pipeline
//                control path (sequencer states, default timeout, NOP bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Pipeline sequencer states
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERR       = 2'd2
  } pipe_state_e;

  // Default number of data-memory wait cycles tolerated before lockup
  localparam int DMEM_TIMEOUT_DEF = 255;

  // Bubble loaded by a flushed pipeline register: addi x0, x0, 0 with all
  // architectural write enables cleared
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic        NOP_WE    = 1'b0;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Central stall/flush sequencer. Merges load-use stalls, EX
//                branch redirects and the data-memory handshake into per-
//                register enables/flushes and the PC enable. Freezes the whole
//                pipeline during multi-cycle data-memory accesses and locks up
//                in ERR on a data-memory timeout.
//                Optional feature macro: PIPE_PERF_EN (stall/flush counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             dmem_wait_o,
  output logic             err_o
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int                  C_WCNT_W    = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [C_WCNT_W-1:0] C_WAIT_LAST = C_WCNT_W'(DMEM_TIMEOUT - 1);

  pipe_state_e         r_state;
  logic [C_WCNT_W-1:0] r_wait_cnt;
  logic                r_err;
  logic                r_dmem_wait;

  logic w_mem_stall;
  logic w_mem_done;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  // A memory handshake only counts while MEM actually holds a load/store
  assign w_mem_stall = dmem_req_i & ~dmem_ready_i;
  assign w_mem_done  = dmem_req_i &  dmem_ready_i;

  // Zero-latency enable/flush decode; outside RUN the pipeline is frozen
  always_comb begin
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_mem_wb_en   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_pc_en     = 1'b0;
          w_if_id_en  = 1'b0;
          w_id_ex_en  = 1'b0;
          w_ex_mem_en = 1'b0;
          w_mem_wb_en = 1'b0;
        end else if (branch_taken_i) begin
          // Branch beats load-use: the stalled ID instruction is wrong-path
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (load_use_i) begin
          // Hold PC and IF/ID, drop one bubble into EX, let older work drain
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_id_ex_flush = 1'b1;
        end
      end
      default: begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_en  = 1'b0;
        w_ex_mem_en = 1'b0;
        w_mem_wb_en = 1'b0;
      end
    endcase
  end

  // Sequencer: RUN -> DMEM_WAIT on a memory stall, back on ready, ERR on timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_dmem_wait <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state     <= DMEM_WAIT;
            r_dmem_wait <= 1'b1;
            r_wait_cnt  <= '0;
          end
        end
        DMEM_WAIT: begin
          if (w_mem_done) begin
            r_state     <= RUN;
            r_dmem_wait <= 1'b0;
            r_wait_cnt  <= '0;
          end else if (r_wait_cnt == C_WAIT_LAST) begin
            r_state     <= ERR;
            r_dmem_wait <= 1'b0;
            r_err       <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + C_WCNT_W'(1);
          end
        end
        ERR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state     <= ERR;
          r_dmem_wait <= 1'b0;
          r_err       <= 1'b1;
        end
      endcase
    end
  end

  assign pc_en_o       = w_pc_en;
  assign if_id_en_o    = w_if_id_en;
  assign id_ex_en_o    = w_id_ex_en;
  assign ex_mem_en_o   = w_ex_mem_en;
  assign mem_wb_en_o   = w_mem_wb_en;
  assign if_id_flush_o = w_if_id_flush;
  assign id_ex_flush_o = w_id_ex_flush;
  assign dmem_wait_o   = r_dmem_wait;
  assign err_o         = r_err;

`ifdef PIPE_PERF_EN
  logic             w_branch_flush;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_cnt;

  // A branch flush is only applied when RUN is not overridden by a memory stall
  assign w_branch_flush = (r_state == RUN) & ~w_mem_stall & branch_taken_i;

  // Free-running wrap-around counters of PC-stalled cycles and branch flushes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cycles <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (!w_pc_en) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_branch_flush) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_cnt_o    = r_flush_cnt;
`endif

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl (DMEM_TIMEOUT = 4).
//                Directed scenarios plus randomized traffic against a
//                behavioural model. Counter checks follow PIPE_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 32;

  // {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, dmem_wait, err}
  localparam logic [8:0] E_IDLE   = 9'b11111_00_0_0;
  localparam logic [8:0] E_FROZEN = 9'b00000_00_0_0;
  localparam logic [8:0] E_WAIT   = 9'b00000_00_1_0;
  localparam logic [8:0] E_ERR    = 9'b00000_00_0_1;
  localparam logic [8:0] E_BR     = 9'b11111_11_0_0;
  localparam logic [8:0] E_LU     = 9'b00111_01_0_0;

  logic clk_i          = 1'b0;
  logic rst_i          = 1'b0;
  logic load_use_i     = 1'b0;
  logic branch_taken_i = 1'b0;
  logic dmem_req_i     = 1'b0;
  logic dmem_ready_i   = 1'b0;
  logic pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic if_id_flush_o, id_ex_flush_o, dmem_wait_o, err_o;
`ifdef PIPE_PERF_EN
  logic [CW-1:0] stall_cycles_o, flush_cnt_o;
`endif

  logic [8:0] obs;
  assign obs = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
                if_id_flush_o, id_ex_flush_o, dmem_wait_o, err_o};

  int checks = 0;
  int fails  = 0;

  // Behavioural model: cycles spent waiting on memory (-1 = not waiting)
  int          m_wait;
  bit          m_err;
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_flush;

  pipeline_ctrl #(.DMEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_use_i     (load_use_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .pc_en_o        (pc_en_o),
    .if_id_en_o     (if_id_en_o),
    .id_ex_en_o     (id_ex_en_o),
    .ex_mem_en_o    (ex_mem_en_o),
    .mem_wb_en_o    (mem_wb_en_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .dmem_wait_o    (dmem_wait_o),
    .err_o          (err_o)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model_outs();
    if (m_err) return E_ERR;
    if (m_wait >= 0) return E_WAIT;
    if (dmem_req_i && !dmem_ready_i) return E_FROZEN;
    if (branch_taken_i) return E_BR;
    if (load_use_i) return E_LU;
    return E_IDLE;
  endfunction

  task automatic model_reset();
    m_wait  = -1;
    m_err   = 1'b0;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic model_tick(input logic [8:0] e);
    if (!e[8]) m_stall = m_stall + 1;
    if (!m_err && m_wait < 0 && !(dmem_req_i && !dmem_ready_i) && branch_taken_i)
      m_flush = m_flush + 1;
    if (m_err) begin
      m_err = 1'b1;
    end else if (m_wait >= 0) begin
      if (dmem_req_i && dmem_ready_i) m_wait = -1;
      else if (m_wait + 1 >= TMO) begin m_wait = -1; m_err = 1'b1; end
      else m_wait = m_wait + 1;
    end else if (dmem_req_i && !dmem_ready_i) begin
      m_wait = 0;
    end
  endtask

  task automatic clear_inputs();
    load_use_i = 0; branch_taken_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
  endtask

  // Reset spanning one clock edge; returns 1 ns after a rising edge
  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL reset_outs: got %b expected %b", obs, E_IDLE); end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cycles_o !== 0 || flush_cnt_o !== 0) begin
      fails++; $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_cycles_o, flush_cnt_o);
    end
`endif
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== E_IDLE) begin fails++; $display("FAIL idle cyc%0d: got %b expected %b", i, obs, E_IDLE); end
`ifdef PIPE_PERF_EN
      checks++;
      if (stall_cycles_o !== 0 || flush_cnt_o !== 0) begin
        fails++; $display("FAIL idle_cnt cyc%0d: got %0d/%0d expected 0/0", i, stall_cycles_o, flush_cnt_o);
      end
`endif
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== E_LU) begin fails++; $display("FAIL load_use: got %b expected %b", obs, E_LU); end
    @(posedge clk_i);
    #1 load_use_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL load_use_after: got %b expected %b", obs, E_IDLE); end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cycles_o !== 1 || flush_cnt_o !== 0) begin
      fails++; $display("FAIL load_use_cnt: got %0d/%0d expected 1/0", stall_cycles_o, flush_cnt_o);
    end
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_branch_load_use();
    do_reset();
    load_use_i = 1'b1; branch_taken_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== E_BR) begin fails++; $display("FAIL branch_lu: got %b expected %b", obs, E_BR); end
    @(posedge clk_i);
    #1 clear_inputs();
    @(negedge clk_i);
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL branch_lu_after: got %b expected %b", obs, E_IDLE); end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cycles_o !== 0 || flush_cnt_o !== 1) begin
      fails++; $display("FAIL branch_lu_cnt: got %0d/%0d expected 0/1", stall_cycles_o, flush_cnt_o);
    end
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_dmem_wait();
    do_reset();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0; branch_taken_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== E_FROZEN) begin fails++; $display("FAIL dmem_req_cycle: got %b expected %b", obs, E_FROZEN); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk_i);
      #1;
      if (i == 3) dmem_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (obs !== E_WAIT) begin fails++; $display("FAIL dmem_wait cyc%0d: got %b expected %b", i, obs, E_WAIT); end
    end
    @(posedge clk_i);
    #1 dmem_req_i = 1'b0; dmem_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== E_BR) begin fails++; $display("FAIL dmem_first_run: got %b expected %b", obs, E_BR); end
    @(posedge clk_i);
    #1 branch_taken_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL dmem_after: got %b expected %b", obs, E_IDLE); end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cycles_o !== 4 || flush_cnt_o !== 1) begin
      fails++; $display("FAIL dmem_cnt: got %0d/%0d expected 4/1", stall_cycles_o, flush_cnt_o);
    end
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_timeout_err();
    logic [8:0] exp;
    do_reset();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = (k == 0) ? E_FROZEN : ((k <= TMO) ? E_WAIT : E_ERR);
      @(negedge clk_i);
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL timeout cyc%0d: got %b expected %b", k, obs, exp); end
`ifdef PIPE_PERF_EN
      checks++;
      if (stall_cycles_o !== CW'(k)) begin
        fails++; $display("FAIL timeout_cnt cyc%0d: got %0d expected %0d", k, stall_cycles_o, k);
      end
`endif
      @(posedge clk_i);
      #1;
    end
    dmem_req_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL err_async_reset: got %b expected %b", obs, E_IDLE); end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cycles_o !== 0 || flush_cnt_o !== 0) begin
      fails++; $display("FAIL err_reset_cnt: got %0d/%0d expected 0/0", stall_cycles_o, flush_cnt_o);
    end
`endif
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL err_after_reset: got %b expected %b", obs, E_IDLE); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== ((k == 0) ? E_FROZEN : E_WAIT)) begin
        fails++; $display("FAIL wait_before_reset cyc%0d: got %b", k, obs);
      end
      if (k < 3) begin
        @(posedge clk_i);
        #1;
      end
    end
    #1 dmem_req_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL wait_async_reset: got %b expected %b", obs, E_IDLE); end
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1 dmem_req_i = 1'b1; dmem_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL ready_first_cycle: got %b expected %b", obs, E_IDLE); end
    @(posedge clk_i);
    #1 clear_inputs();
    @(negedge clk_i);
    checks++;
    if (obs !== E_IDLE) begin fails++; $display("FAIL after_ready_first: got %b expected %b", obs, E_IDLE); end
`ifdef PIPE_PERF_EN
    checks++;
    if (stall_cycles_o !== 0) begin
      fails++; $display("FAIL reset_wait_cnt: got %0d expected 0", stall_cycles_o);
    end
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic [8:0] exp;
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      load_use_i     = ($urandom_range(0, 3) == 0);
      branch_taken_i = ($urandom_range(0, 3) == 0);
      dmem_req_i     = (m_wait >= 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      dmem_ready_i   = $urandom_range(0, 1) == 1;
      @(negedge clk_i);
      exp = model_outs();
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL random cyc%0d: got %b expected %b", i, obs, exp); end
`ifdef PIPE_PERF_EN
      checks++;
      if (stall_cycles_o !== m_stall || flush_cnt_o !== m_flush) begin
        fails++; $display("FAIL random_cnt cyc%0d: got %0d/%0d expected %0d/%0d",
                          i, stall_cycles_o, flush_cnt_o, m_stall, m_flush);
      end
`endif
      model_tick(exp);
      @(posedge clk_i);
      #1;
      if (m_err && $urandom_range(0, 1) == 0) begin
        do_reset();
        model_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_branch_load_use();
    test_dmem_wait();
    test_timeout_err();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
